// File: rtl/jelly_data_shift_buffer_pkg.sv
// Shared helpers for jelly_data_shift_buffer: tap-select and fill-count widths,
// and the index width used by each tap's range check.
package jelly_data_shift_buffer_pkg;

  // Tap select is widened to this before comparing against stage indices,
  // so any select value at or beyond DEPTH simply matches no stage.
  localparam int unsigned TAP_INDEX_WIDTH = 32;

  function automatic int unsigned sel_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned fill_width(input int unsigned sel_w);
    return sel_w + 1;
  endfunction

endpackage

// File: rtl/jelly_data_shift_buffer_tap.sv
// One output channel of jelly_data_shift_buffer: selects a stage/tag pair,
// zeroes out-of-range selects, and registers the result.
module jelly_data_shift_buffer_tap
  import jelly_data_shift_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned SEL_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                        reset,
  input  logic                        clk,
  input  logic                        cke,
  input  logic                        flush,
  input  logic [DEPTH*DATA_WIDTH-1:0] stage_data,
  input  logic [DEPTH-1:0]            tag,
  input  logic [SEL_WIDTH-1:0]        sel,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid
);

  logic [TAP_INDEX_WIDTH-1:0] index;
  logic [DATA_WIDTH-1:0]      tap_data;
  logic                       tap_valid;

  // Comparator-per-stage mux: a select beyond DEPTH-1 matches nothing and
  // leaves the zero defaults, which doubles as the range check.
  always_comb begin
    index     = TAP_INDEX_WIDTH'(sel);
    tap_data  = '0;
    tap_valid = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (index == k) begin
        tap_data  = stage_data[k*DATA_WIDTH +: DATA_WIDTH];
        tap_valid = tag[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (cke) out_data <= tap_data;
      if (flush)    out_valid <= 1'b0;
      else if (cke) out_valid <= tap_valid;
    end
  end

endmodule

// File: rtl/jelly_data_shift_buffer.sv
// Tagged shift register with CHANNELS independently selectable output taps.
// Define JELLY_DATA_SHIFT_BUFFER_FILL_COUNT_EN to build the out_fill counter.
module jelly_data_shift_buffer
  import jelly_data_shift_buffer_pkg::*;
#(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned SEL_WIDTH  = sel_width(DEPTH),
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                           reset,
  input  logic                           clk,
  input  logic                           cke,
  input  logic                           flush,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           in_valid,
  input  logic [CHANNELS*SEL_WIDTH-1:0]  sel,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]            out_valid,
  output logic [SEL_WIDTH:0]             out_fill
);

  logic [DEPTH*DATA_WIDTH-1:0] stage;
  logic [DEPTH-1:0]            tag;

  // Data stages carry no reset so they map onto shift-register primitives;
  // stale contents are masked by the tags.
  always_ff @(posedge clk) begin
    if (cke) stage <= {stage[(DEPTH-1)*DATA_WIDTH-1:0], in_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      tag <= '0;
    else if (flush) tag <= '0;
    else if (cke)   tag <= {tag[DEPTH-2:0], in_valid};
  end

`ifdef JELLY_DATA_SHIFT_BUFFER_FILL_COUNT_EN
  localparam int unsigned FILL_WIDTH = fill_width(SEL_WIDTH);

  logic [FILL_WIDTH-1:0] fill;

  // Count tracks tag population exactly, so it cannot leave 0..DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill <= '0;
    end else if (flush) begin
      fill <= '0;
    end else if (cke) begin
      if (in_valid && !tag[DEPTH-1])      fill <= fill + FILL_WIDTH'(1);
      else if (!in_valid && tag[DEPTH-1]) fill <= fill - FILL_WIDTH'(1);
    end
  end

  assign out_fill = fill;
`else
  assign out_fill = '0;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_tap
    jelly_data_shift_buffer_tap #(
      .DEPTH      (DEPTH),
      .SEL_WIDTH  (SEL_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_tap (
      .reset      (reset),
      .clk        (clk),
      .cke        (cke),
      .flush      (flush),
      .stage_data (stage),
      .tag        (tag),
      .sel        (sel[c*SEL_WIDTH +: SEL_WIDTH]),
      .out_data   (out_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .out_valid  (out_valid[c])
    );
  end

endmodule

// File: tb/tb_jelly_data_shift_buffer.sv
// Scoreboard bench for jelly_data_shift_buffer (DEPTH=8, CHANNELS=2, SEL_WIDTH=4).
module tb_jelly_data_shift_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cke = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  sel = '0;
  logic [15:0] out_data;
  logic [1:0]  out_valid;
  logic [4:0]  out_fill;
  logic        probe = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef JELLY_DATA_SHIFT_BUFFER_FILL_COUNT_EN
  localparam logic [4:0] FILL_MASK = '1;
`else
  localparam logic [4:0] FILL_MASK = '0;
`endif

  typedef struct {
    string      name;
    bit         c_d[2];
    bit         c_v[2];
    logic [7:0] d[2];
    logic       v[2];
    logic [4:0] f;
  } exp_t;

  exp_t q[$];

  jelly_data_shift_buffer #(
    .CHANNELS   (2),
    .DEPTH      (8),
    .SEL_WIDTH  (4),
    .DATA_WIDTH (8)
  ) dut (
    .reset     (reset),
    .clk       (clk),
    .cke       (cke),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_fill  (out_fill)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string n, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp_v);
    end
  endtask

  // Expected tap output after edge ee: the sample that entered on edge ee-s-1.
  function automatic exp_t mk(input string n, input int ee, input int s0, input int s1,
                              input int base, input bit alt, input int fill);
    exp_t x;
    x.name = n;
    x.f    = 5'(fill) & FILL_MASK;
    for (int ch = 0; ch < 2; ch++) begin
      int s   = (ch == 0) ? s0 : s1;
      int src = ee - s - 1;
      bit v;
      x.c_v[ch] = 1'b1;
      if (s >= 8) begin
        x.c_d[ch] = 1'b1;
        x.d[ch]   = 8'd0;
        x.v[ch]   = 1'b0;
      end else begin
        v         = (src >= 1) && (!alt || (src % 2 == 1));
        x.v[ch]   = v;
        x.c_d[ch] = v;
        x.d[ch]   = 8'(base + src);
      end
    end
    return x;
  endfunction

  function automatic exp_t mk_zero(input string n);
    exp_t x;
    x.name = n;
    x.f    = 5'd0;
    for (int ch = 0; ch < 2; ch++) begin
      x.c_d[ch] = 1'b1;
      x.c_v[ch] = 1'b1;
      x.d[ch]   = 8'd0;
      x.v[ch]   = 1'b0;
    end
    return x;
  endfunction

  function automatic int alt_fill(input int ee);
    int cnt = 0;
    for (int i = (ee > 8 ? ee - 7 : 1); i <= ee; i++)
      if (i % 2 == 1) cnt++;
    return cnt;
  endfunction

  task automatic step(input logic c, input logic [7:0] d, input logic v,
                      input logic f, input exp_t e);
    @(negedge clk);
    cke = c; in_data = d; in_valid = v; flush = f;
    q.push_back(e);
  endtask

  task automatic do_reset(input logic [3:0] s0, input logic [3:0] s1);
    @(negedge clk);
    reset = 1'b1; cke = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    sel = {s1, s0};
    q.push_back(mk_zero("reset"));
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: one expectation per sampled edge, plus the asynchronous probe.
  initial begin
    forever begin
      @(posedge clk or posedge probe);
      #1;
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        for (int ch = 0; ch < 2; ch++) begin
          if (e.c_d[ch]) check($sformatf("%s ch%0d data", e.name, ch), out_data[ch*8 +: 8], e.d[ch]);
          if (e.c_v[ch]) check($sformatf("%s ch%0d valid", e.name, ch), out_valid[ch], e.v[ch]);
        end
        check($sformatf("%s fill", e.name), out_fill, e.f);
      end
    end
  end

  initial begin
    exp_t e;
    int   k;

    // Latency with sel={0,7}
    do_reset(4'd0, 4'd7);
    for (int ee = 1; ee <= 12; ee++)
      step(1'b1, 8'(ee), 1'b1, 1'b0, mk($sformatf("lat e%0d", ee), ee, 0, 7, 0, 1'b0, ee > 8 ? 8 : ee));

    // Clock enable gating with sel=3; ch1 out of range
    do_reset(4'd3, 4'd9);
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) k++;
      step((i % 2 == 0), (i % 2 == 0) ? 8'(k) : 8'hEE, 1'b1, 1'b0,
           mk($sformatf("cke i%0d", i), k, 3, 9, 0, 1'b0, k));
    end

    // Fill then flush
    do_reset(4'd0, 4'd9);
    for (int ee = 1; ee <= 8; ee++)
      step(1'b1, 8'(8'h0F + ee), 1'b1, 1'b0, mk($sformatf("fill e%0d", ee), ee, 0, 9, 8'h0F, 1'b0, ee));
    e = mk("flush", 0, 0, 9, 0, 1'b0, 0);
    e.c_d[0] = 1'b1; e.d[0] = 8'h17; e.v[0] = 1'b0;
    step(1'b1, 8'h18, 1'b1, 1'b1, e);
    e.name = "post flush1"; e.d[0] = 8'h18;
    step(1'b1, 8'h19, 1'b0, 1'b0, e);
    e.name = "post flush2"; e.d[0] = 8'h19; e.f = 5'd1 & FILL_MASK;
    step(1'b1, 8'h1A, 1'b1, 1'b0, e);
    e.name = "refill"; e.d[0] = 8'h1A; e.v[0] = 1'b1;
    step(1'b1, 8'h1B, 1'b0, 1'b0, e);
    e.name = "flush nocke"; e.v[0] = 1'b0; e.f = 5'd0;
    step(1'b0, 8'h1C, 1'b1, 1'b1, e);

    // Alternating valid
    do_reset(4'd0, 4'd2);
    for (int ee = 1; ee <= 20; ee++)
      step(1'b1, 8'(ee), (ee % 2 == 1), 1'b0,
           mk($sformatf("alt e%0d", ee), ee, 0, 2, 0, 1'b1, alt_fill(ee)));

    // Asynchronous reset mid-stream
    do_reset(4'd1, 4'd0);
    for (int ee = 1; ee <= 5; ee++)
      step(1'b1, 8'(8'h30 + ee), 1'b1, 1'b0, mk($sformatf("pre e%0d", ee), ee, 1, 0, 8'h30, 1'b0, ee));
    @(negedge clk);
    #2 reset = 1'b1;
    #1 q.push_back(mk_zero("async reset"));
    probe = 1'b1;
    #1 probe = 1'b0;
    @(negedge clk);
    reset = 1'b0; cke = 1'b0; in_valid = 1'b0;
    for (int ee = 1; ee <= 4; ee++)
      step(1'b1, 8'(8'h40 + ee), 1'b1, 1'b0, mk($sformatf("post e%0d", ee), ee, 1, 0, 8'h40, 1'b0, ee));

    @(negedge clk);
    cke = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
